// File: rtl/block_averager_pkg.sv
// Shared types and constants for the block averager.
// FSM state encoding and rounding-mode selectors.
package block_averager_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;

endpackage

// File: rtl/block_averager.sv
// Averages non-overlapping windows of 2^LOG2_N unsigned samples.
// One result per window, held until the consumer takes it.
module block_averager
  import block_averager_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 2,
  parameter int ROUND  = RND_TRUNC
) (
  input  logic                           clk_2,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [(LOG2_N==0?1:LOG2_N)-1:0] win_cnt
);

  localparam int CW  = (LOG2_N == 0) ? 1 : LOG2_N;
  localparam int AW  = DATA_W + LOG2_N;
  localparam int RND =
    (ROUND == RND_HALF_UP) ? (2**LOG2_N) / 2 : 0;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0]     r_acc;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_out;

  logic          w_acc_en;
  logic          w_last;
  logic [AW-1:0] w_tot;
  logic [AW:0]   w_sum;

  assign in_ready = reset_n && !clear &&
                    (r_state != HOLD);
  assign w_acc_en = in_valid && in_ready;
  assign w_last   = (r_cnt == CW'((2**LOG2_N) - 1));

  // A full window of max samples fits AW bits exactly.
  assign w_tot = r_acc + AW'(in_data);
  assign w_sum = {1'b0, w_tot} + (AW+1)'(RND);

  assign out_valid = (r_state == HOLD);
  assign out_data  = r_out;
  assign win_cnt   = r_cnt;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE, ACCUM: begin
          if (w_acc_en) begin
            w_next = w_last ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            w_next = IDLE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_out <= '0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_acc_en) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_out <= DATA_W'(w_sum >> LOG2_N);
      end else begin
        r_acc <= w_tot;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_block_averager.sv
// Directed bench: truncate, round-half-up and pass-through
// instances driven with hand-computed windows.
module tb_block_averager;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       a_ready, a_valid;
  logic [7:0] a_data;
  logic [1:0] a_cnt;

  logic       r_ready, r_valid;
  logic [7:0] r_data;
  logic [1:0] r_cnt;

  logic       p_valid;
  logic [7:0] p_data;
  logic       p_oready;
  logic       p_ready, p_ovalid;
  logic [7:0] p_odata;
  logic [0:0] p_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_2 = ~clk_2;

  block_averager #(.DATA_W(8), .LOG2_N(2), .ROUND(0)) u_trunc (
    .clk_2(clk_2), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(a_ready),
    .in_data(in_data), .out_valid(a_valid),
    .out_ready(out_ready), .out_data(a_data),
    .win_cnt(a_cnt)
  );

  block_averager #(.DATA_W(8), .LOG2_N(2), .ROUND(1)) u_round (
    .clk_2(clk_2), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(r_ready),
    .in_data(in_data), .out_valid(r_valid),
    .out_ready(out_ready), .out_data(r_data),
    .win_cnt(r_cnt)
  );

  block_averager #(.DATA_W(8), .LOG2_N(0), .ROUND(0)) u_pass (
    .clk_2(clk_2), .reset_n(reset_n), .clear(clear),
    .in_valid(p_valid), .in_ready(p_ready),
    .in_data(p_data), .out_valid(p_ovalid),
    .out_ready(p_oready), .out_data(p_odata),
    .win_cnt(p_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!a_ready && n < 50) begin
      @(negedge clk_2);
      n++;
    end
    if (!a_ready) chk("push_timeout", a_ready, 1);
    @(posedge clk_2);
    @(negedge clk_2);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic push4(input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    push(d0);
    push(d1);
    push(d2);
    push(d3);
  endtask

  task automatic consume;
    @(posedge clk_2);
    @(negedge clk_2);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    p_valid   = 1'b0;
    p_data    = 8'd0;
    p_oready  = 1'b1;

    repeat (2) @(negedge clk_2);
    #1;
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_ready", a_ready, 0);
    @(negedge clk_2);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", a_ready, 1);

    // 10,20,30,40 -> 25 in both modes, 1-cycle latency
    push(8'd10);
    push(8'd20);
    push(8'd30);
    chk("t1_cnt3", a_cnt, 3);
    chk("t1_no_early", a_valid, 0);
    push(8'd40);
    chk("t1_valid", a_valid, 1);
    chk("t1_data", a_data, 25);
    chk("t1_rdata", r_data, 25);
    chk("t1_busy", a_ready, 0);
    chk("t1_cnt0", a_cnt, 0);
    consume();
    chk("t1_one_cycle", a_valid, 0);
    chk("t1_ready_back", a_ready, 1);

    // 1,2,2,2: sum 7 -> trunc 1, round 2
    push4(8'd1, 8'd2, 8'd2, 8'd2);
    chk("t2_trunc", a_data, 1);
    chk("t2_round", r_data, 2);
    consume();

    // full-scale window never wraps
    push4(8'd255, 8'd255, 8'd255, 8'd255);
    chk("t3_trunc", a_data, 255);
    chk("t3_round", r_data, 255);
    consume();

    // back-pressure: 50,60,70,80 -> 65 held 5 cycles
    out_ready = 1'b0;
    push4(8'd50, 8'd60, 8'd70, 8'd80);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", a_valid, 1);
      chk("t4_hold_data", a_data, 65);
      chk("t4_hold_ready", a_ready, 0);
      @(negedge clk_2);
      #1;
    end
    out_ready = 1'b1;
    chk("t4_last_valid", a_valid, 1);
    chk("t4_last_ready", a_ready, 0);
    consume();
    chk("t4_consumed", a_valid, 0);
    chk("t4_ready_back", a_ready, 1);

    // clear mid-window
    push(8'd100);
    push(8'd100);
    chk("t5_cnt2", a_cnt, 2);
    clear = 1'b1;
    #1;
    chk("t5_clr_ready", a_ready, 0);
    @(posedge clk_2);
    @(negedge clk_2);
    clear = 1'b0;
    #1;
    chk("t5_cnt_clr", a_cnt, 0);
    push4(8'd4, 8'd4, 8'd4, 8'd4);
    chk("t5_data", a_data, 4);
    chk("t5_rdata", r_data, 4);
    consume();

    // clear discards a pending result
    out_ready = 1'b0;
    push4(8'd40, 8'd40, 8'd40, 8'd40);
    chk("t6_pend", a_valid, 1);
    clear = 1'b1;
    @(posedge clk_2);
    @(negedge clk_2);
    clear = 1'b0;
    #1;
    chk("t6_dropped", a_valid, 0);
    chk("t6_ready", a_ready, 1);
    out_ready = 1'b1;

    // reset mid-window
    push(8'd1);
    push(8'd2);
    push(8'd3);
    chk("t7_cnt3", a_cnt, 3);
    reset_n = 1'b0;
    #1;
    chk("t7_rst_valid", a_valid, 0);
    chk("t7_rst_data", a_data, 0);
    chk("t7_rst_cnt", a_cnt, 0);
    chk("t7_rst_ready", a_ready, 0);
    @(negedge clk_2);
    reset_n = 1'b1;
    #1;
    chk("t7_ready", a_ready, 1);
    push4(8'd8, 8'd8, 8'd8, 8'd8);
    chk("t7_data", a_data, 8);
    chk("t7_rdata", r_data, 8);
    consume();

    // LOG2_N=0 pass-through: 7 then 9
    p_valid = 1'b1;
    p_data  = 8'd7;
    #1;
    chk("p_ready0", p_ready, 1);
    @(posedge clk_2);
    @(negedge clk_2);
    p_valid = 1'b0;
    #1;
    chk("p_valid7", p_ovalid, 1);
    chk("p_data7", p_odata, 7);
    chk("p_busy", p_ready, 0);
    chk("p_cnt", p_cnt, 0);
    consume();
    chk("p_ready1", p_ready, 1);
    p_valid = 1'b1;
    p_data  = 8'd9;
    @(posedge clk_2);
    @(negedge clk_2);
    p_valid = 1'b0;
    #1;
    chk("p_valid9", p_ovalid, 1);
    chk("p_data9", p_odata, 9);
    consume();
    chk("p_done", p_ovalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/block_averager.md
BLOCK_AVERAGER -- requirements
Module: block_averager

Interface
REQ-001 Parameter DATA_W, default 8, sample and result width in bits.
REQ-002 Parameter LOG2_N, default 2, log2 of the window length; window N = 2^LOG2_N samples; legal range 0..8.
REQ-003 Parameter ROUND, default 0, result mode; 0 = truncate, 1 = round-half-up.
REQ-004 Port clk_2, input, 1 bit, clock; all state changes on the rising edge.
REQ-005 Port reset_n, input, 1 bit, reset; asynchronous, active-low.
REQ-006 Port clear, input, 1 bit, synchronous flush of the current window.
REQ-007 Port in_valid, input, 1 bit, in_data holds a sample.
REQ-008 Port in_ready, output, 1 bit, block accepts a sample this cycle.
REQ-009 Port in_data, input, DATA_W bits, unsigned sample.
REQ-010 Port out_valid, output, 1 bit, out_data holds a result.
REQ-011 Port out_ready, output consumer, input, 1 bit, consumer takes the result this cycle.
REQ-012 Port out_data, output, DATA_W bits, unsigned window average.
REQ-013 Port win_cnt, output, LOG2_N bits (1 bit when LOG2_N=0, tied 0), samples accepted in the current window.

Function
REQ-014 A sample is accepted on a clock edge where in_valid && in_ready; no other condition.
REQ-015 FSM states: IDLE (window empty), ACCUM (1..N-1 samples held), HOLD (result pending).
REQ-016 IDLE -> ACCUM on acceptance when N>1; IDLE or ACCUM -> HOLD on the Nth accepted sample.
REQ-017 HOLD -> IDLE on the edge where out_valid && out_ready.
REQ-018 in_ready = 1 in IDLE and ACCUM, 0 in HOLD, and 0 in any cycle where clear = 1.
REQ-019 The accumulator is DATA_W+LOG2_N bits wide and never overflows.
REQ-020 On the Nth acceptance the block registers out_data = (acc + sample + (ROUND ? 2^(LOG2_N-1) : 0)) >> LOG2_N. The rounding term is 0 when LOG2_N=0.
REQ-021 On the same edge the block clears acc and win_cnt. out_valid goes high in the following cycle, giving 1-cycle latency from the Nth acceptance.
REQ-022 out_data and out_valid stay stable while out_valid=1 and out_ready=0.
REQ-023 out_ready while out_valid=0 has no effect.
REQ-024 The block does not accept a new sample in the cycle the result is consumed. in_ready rises the cycle after consumption.
REQ-025 clear=1 has the highest priority after reset. On that edge: acc=0, win_cnt=0, out_valid=0, state=IDLE. Any pending result is discarded and no sample is accepted that cycle.
REQ-026 LOG2_N=0 acts as a registered pass-through with a handshake: each sample produces out_data = in_data.
REQ-027 win_cnt wraps from N-1 to 0 on the Nth acceptance.

Reset
REQ-028 Assertion of reset_n=0 asynchronously forces: state=IDLE, acc=0, win_cnt=0, out_valid=0, out_data=0.
REQ-029 in_ready is 0 while reset_n=0 and 1 in the first cycle after deassertion.
REQ-030 Reset mid-window or mid-HOLD discards all partial sums and pending results.

Structure
REQ-031 A shared package block_averager_pkg holds the FSM state enum (IDLE, ACCUM, HOLD) and the ROUND mode constants (RND_TRUNC=0, RND_HALF_UP=1).
REQ-032 The FSM and datapath are a single module with no sub-module. Window length is set only via LOG2_N, with no divider.

Verification (DATA_W=8, LOG2_N=2 unless noted)
REQ-033 Stimulus: samples 10, 20, 30, 40 back-to-back, out_ready=1. Response: out_data=25 with out_valid for 1 cycle, exactly 1 cycle after the 4th acceptance.
REQ-034 Stimulus: samples 1, 2, 2, 2. Response: ROUND=0 gives out_data=1; ROUND=1 gives out_data=2.
REQ-035 Stimulus: samples 255, 255, 255, 255, in both modes. Response: out_data=255, with no overflow or wrap.
REQ-036 Stimulus: a complete window with out_ready held 0 for 5 cycles. Response: out_valid stays 1, out_data stays stable, in_ready stays 0. Consumption occurs on the 6th cycle and in_ready returns the cycle after.
REQ-037 Stimulus: samples 100, 100, then a clear pulse, then 4, 4, 4, 4. Response: win_cnt reads 0 after the clear and out_data=4.
REQ-038 Stimulus: reset_n pulsed low after 3 samples, then 8, 8, 8, 8. Response: all outputs are 0 during reset and out_data=8. With LOG2_N=0, samples 7 then 9 produce out_data 7 then 9.
